// File: rtl/seq_arb_pkg.sv
// Shared types and default sizing for the serial-core stream arbiter.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_BURST_LEN = 8;

endpackage

// File: rtl/seq_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down, so the nearest hit to ptr_i is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/seq_stream_arbiter.sv
// Round-robin burst arbiter that time-shares one serial 2-state core between N_REQ requesters.
module seq_stream_arbiter
  import seq_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int BURST_LEN = DEF_BURST_LEN,
  localparam int ID_W      = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in_bit,
  output logic [N_REQ-1:0] gnt,
  output logic             core_clr,
  output logic             core_en,
  output logic             core_a,
  input  logic             core_y,
  output logic             out_bit,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  output logic             done
);

  arb_state_e      state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic            out_valid_q;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic            busy;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign ptr_d = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Core output lags its enabled step by one cycle, so the qualifier does too.
      out_valid_q <= core_en;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign core_clr = (state_q == CLEAR);
  assign core_en  = (state_q == RUN);
  assign core_a   = (state_q == RUN) ? in_bit[owner_q] : 1'b0;
  assign done     = (state_q == DRAIN);
  assign out_id   = busy ? owner_q : '0;
  assign out_bit  = core_y;
  assign out_valid = out_valid_q;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = busy && (owner_q == ID_W'(gi));
    end
  endgenerate

endmodule
